csi2_tx_pattern: RTL
====================

# csi2_tx_pattern

Byte-level MIPI CSI-2 transmitter that emulates a RAW8 image sensor for loopback and bench use. It generates complete frames (Frame Start, RAW8 line packets carrying a deterministic test pattern, Frame End) and distributes them across `NUM_LANE` HS byte lanes. It sits where the D-PHY RX deserializers sit, in front of the lane aligner and packet decoder, so the receive path can be exercised without a camera.

## Interface
- `NUM_LANE`, 2: active lanes; legal values 1, 2, 4.
- `WIDTH`, 64: payload bytes per line (RAW8 word count), 1..65535.
- `LINES`, 4: line packets per frame, ≥1.
- `GAP`, 8: idle cycles after every packet, ≥1.
- `VC`, 0: virtual channel, 2 bits; placed in DI[7:6].
- `clk`  in  1: byte clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: while high, frames are sent back-to-back.
- `hs_en`  out  1: high from the sync cycle through the last packet cycle.
- `lane_vld`  out  `NUM_LANE`: per-lane byte valid.
- `lane_data`  out  `NUM_LANE`×8: per-lane byte (`bus8_t` array, lane 0 = [7:0]).
- `frame_done`  out  1: one-cycle pulse in the last GAP cycle after FE.

## Operation
- States: IDLE, SYNC, BODY, GAP.
- IDLE → SYNC when `enable`=1. SYNC lasts 1 cycle: all lanes carry 0xB8, `lane_vld` all 1.
- BODY: the packet body is one byte stream. Short packet: 4 bytes. Long packet: 4 + `WIDTH` + 2 bytes. Stream byte n goes to lane n mod `NUM_LANE` in cycle ⌊n/`NUM_LANE`⌋.
- In the final BODY cycle, lanes with no byte drive `lane_vld`=0 and data 0x00.
- Header bytes are DI, WC[7:0], WC[15:8], ECC. DI = {VC, DT}.
- ECC is the CSI-2 6-bit Hamming code over the 24 bits {WC, DI}, with ECC[7:6]=0.
- Packet order per frame: FS (DT 0x00, WC = frame number), `LINES` × RAW8 long packets (DT 0x2A, WC = `WIDTH`), FE (DT 0x01, WC = frame number).
- Pixel byte for column x, line y, frame f: (x + y + f[7:0]) mod 256.
- Long packets end with a 2-byte CRC, low byte first.
- BODY → GAP after the last body cycle. GAP lasts `GAP` cycles with `hs_en`, `lane_vld` and data all 0.
- GAP → SYNC for the next packet. After FE: GAP → SYNC if `enable`=1, otherwise GAP → IDLE.
- Dropping `enable` mid-frame does not abort; the frame completes through FE and its GAP.
- Frame number is 16 bits. It starts at 0 and increments after FE, wrapping 0xFFFF → 0x0000.
- x counter is 16 bits; y counter is 16 bits.

## Timing
- Reset: state IDLE; `hs_en`, `lane_vld`, `lane_data`, `frame_done` = 0; frame number 0; CRC register 0xFFFF.
- All outputs are registered. The first SYNC cycle appears 1 cycle after `enable` is sampled high in IDLE.
- Body cycles per packet = ⌈bytes/`NUM_LANE`⌉. Example: `NUM_LANE`=2, `WIDTH`=64 gives 35 body cycles.
- Per-packet duration = 1 + body cycles + `GAP`.
- `frame_done` coincides with the last GAP cycle of FE. It fires even if `enable` is already low.
- Asserting `rst_n` low mid-packet clears all outputs immediately. The next frame after release is frame 0.

## Configuration
- `CSI_TX_CRC_EN` defined: CRC-16 with polynomial x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, no final XOR, computed over payload bytes only. CRC is reseeded per packet.
- `CSI_TX_CRC_EN` undefined: the two CRC bytes are 0x00, 0x00 (the CSI-2 "CRC not computed" value). No CRC logic is synthesized.

## Test plan
- Reset, `NUM_LANE`=1, `enable`=1 → lane 0 carries B8, 00, 00, 00, 00 (FS of frame 0, ECC 0x00). `hs_en` is high for 5 cycles, then low for `GAP`=8 cycles.
- `NUM_LANE`=2, `WIDTH`=64, `LINES`=4, CRC enabled. Line 0 of frame 0 → header 2A, 40, 00, ECC matching the reference model. Payload 00..3F split even/odd across lanes. 35 body cycles.
- CRC known-answer: `WIDTH`=24 with a pattern override in the bench model. Feed CSI-2 spec bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → CRC bytes F0, 00.
- `NUM_LANE`=4, `WIDTH`=64 → final body cycle has `lane_vld`=4'b0011. Lanes 2 and 3 carry 0x00.
- `enable` dropped during line 1 → the frame finishes through FE. `frame_done` pulses once, then the block stays IDLE. The next `enable` produces FS with WC=0x0001.
- Reset asserted in the middle of a long packet → all outputs 0 the same cycle. After release with `enable`=1, FS WC=0x0000.

Source files
------------

// File: rtl/csi2_tx_pattern_if.sv
//----------------------------------------------------------------------------
// csi2_tx_pattern_if : HS byte-lane bus between the CSI-2 pattern transmitter
//                      and the lane aligner / packet decoder it feeds.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface csi2_tx_pattern_if #(
   parameter int NUM_LANE = 2
);
   typedef logic [7:0] bus8_t;

   logic                  enable;
   logic                  hs_en;
   logic [NUM_LANE-1:0]   lane_vld;
   bus8_t [NUM_LANE-1:0]  lane_data;
   logic                  frame_done;

   modport master (input enable, output hs_en, output lane_vld, output lane_data, output frame_done);
   modport slave  (output enable, input hs_en, input lane_vld, input lane_data, input frame_done);
endinterface

`default_nettype wire

// File: rtl/csi2_tx_pattern.sv
//----------------------------------------------------------------------------
// csi2_tx_pattern : RAW8 CSI-2 frame generator striped over NUM_LANE byte lanes.
//                   CSI_TX_CRC_EN selects real payload CRC instead of 0x0000.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module csi2_tx_pattern #(
   parameter int         NUM_LANE = 2,
   parameter int         WIDTH    = 64,
   parameter int         LINES    = 4,
   parameter int         GAP      = 8,
   parameter logic [1:0] VC       = 2'd0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   csi2_tx_pattern_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_BODY, S_GAP} state_t;
   typedef enum logic [1:0] {K_FS, K_LINE, K_FE} kind_t;

   localparam logic [16:0] SHORT_LEN = 17'd4;
   localparam logic [16:0] LONG_LEN  = 17'(WIDTH + 6);
   localparam logic [16:0] PAY_END   = 17'(WIDTH + 4);
   localparam logic [16:0] STEP      = 17'(NUM_LANE);
   localparam logic [15:0] LAST_Y    = 16'(LINES - 1);
   localparam logic [15:0] LAST_GAP  = 16'(GAP - 1);

   state_t                      state, state_n;
   kind_t                       kind, kind_n;
   logic [15:0]                 frame, frame_n;
   logic [15:0]                 y_cnt, y_n;
   logic [15:0]                 gap_cnt, gap_n;
   logic [16:0]                 pos, pos_n;
   logic                        hs_q, hs_n;
   logic                        done_q, done_n;
   logic [NUM_LANE-1:0]         vld_q, vld_n;
   logic [NUM_LANE-1:0][7:0]    data_q, data_n;
   logic [15:0]                 wc;
   logic [5:0]                  dt;
   logic [7:0]                  di;
   logic [7:0]                  ecc;
   logic [16:0]                 p;
`ifdef CSI_TX_CRC_EN
   logic [15:0]                 crc, crc_n;
`endif

   function automatic logic [16:0] len_of(input kind_t k);
      return (k == K_LINE) ? LONG_LEN : SHORT_LEN;
   endfunction

   // Each ECC bit is the parity of a fixed subset of {WC, DI}.
   function automatic logic [7:0] ecc_of(input logic [23:0] d);
      return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                     ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
   endfunction

`ifdef CSI_TX_CRC_EN
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction
`endif

   always_comb begin
      state_n = state;
      kind_n  = kind;
      frame_n = frame;
      y_n     = y_cnt;
      gap_n   = gap_cnt;
      pos_n   = pos;
      case (state)
         S_IDLE: begin
            if (bus.enable) begin
               state_n = S_SYNC;
               kind_n  = K_FS;
            end
         end
         S_SYNC: begin
            state_n = S_BODY;
            pos_n   = '0;
         end
         S_BODY: begin
            if (pos + STEP >= len_of(kind)) begin
               state_n = S_GAP;
               gap_n   = '0;
            end else begin
               pos_n = pos + STEP;
            end
         end
         S_GAP: begin
            if (gap_cnt == LAST_GAP) begin
               state_n = S_SYNC;
               case (kind)
                  K_FS: begin
                     kind_n = K_LINE;
                     y_n    = '0;
                  end
                  K_LINE: begin
                     if (y_cnt == LAST_Y) kind_n = K_FE;
                     else                 y_n    = y_cnt + 16'd1;
                  end
                  default: begin
                     // enable is only consulted at a frame boundary
                     frame_n = frame + 16'd1;
                     kind_n  = K_FS;
                     if (!bus.enable) state_n = S_IDLE;
                  end
               endcase
            end else begin
               gap_n = gap_cnt + 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Output registers are loaded with what the next state must show.
      hs_n   = (state_n == S_SYNC) || (state_n == S_BODY);
      done_n = (state_n == S_GAP) && (gap_n == LAST_GAP) && (kind_n == K_FE);
      vld_n  = '0;
      data_n = '0;
      p      = '0;
      case (kind_n)
         K_LINE:  dt = 6'h2A;
         K_FE:    dt = 6'h01;
         default: dt = 6'h00;
      endcase
      wc  = (kind_n == K_LINE) ? 16'(WIDTH) : frame_n;
      di  = {VC, dt};
      ecc = ecc_of({wc, di});
`ifdef CSI_TX_CRC_EN
      crc_n = (state_n == S_SYNC) ? 16'hFFFF : crc;
`endif

      if (state_n == S_SYNC) begin
         vld_n = '1;
         for (int i = 0; i < NUM_LANE; i++) data_n[i] = 8'hB8;
      end else if (state_n == S_BODY) begin
         for (int i = 0; i < NUM_LANE; i++) begin
            p = pos_n + 17'(i);
            if (p < len_of(kind_n)) begin
               vld_n[i] = 1'b1;
               if      (p == 17'd0) data_n[i] = di;
               else if (p == 17'd1) data_n[i] = wc[7:0];
               else if (p == 17'd2) data_n[i] = wc[15:8];
               else if (p == 17'd3) data_n[i] = ecc;
               else if (p < PAY_END) begin
                  // (x + y + f) mod 256 with x = p - 4
                  data_n[i] = p[7:0] - 8'd4 + y_n[7:0] + frame_n[7:0];
`ifdef CSI_TX_CRC_EN
                  crc_n = crc_step(crc_n, data_n[i]);
`endif
               end else begin
`ifdef CSI_TX_CRC_EN
                  data_n[i] = (p == PAY_END) ? crc_n[7:0] : crc_n[15:8];
`else
                  data_n[i] = 8'h00;
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         kind    <= K_FS;
         frame   <= '0;
         y_cnt   <= '0;
         gap_cnt <= '0;
         pos     <= '0;
         hs_q    <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= '0;
         data_q  <= '0;
`ifdef CSI_TX_CRC_EN
         crc     <= 16'hFFFF;
`endif
      end else begin
         state   <= state_n;
         kind    <= kind_n;
         frame   <= frame_n;
         y_cnt   <= y_n;
         gap_cnt <= gap_n;
         pos     <= pos_n;
         hs_q    <= hs_n;
         done_q  <= done_n;
         vld_q   <= vld_n;
         data_q  <= data_n;
`ifdef CSI_TX_CRC_EN
         crc     <= crc_n;
`endif
      end
   end

   assign bus.hs_en      = hs_q;
   assign bus.frame_done = done_q;
   assign bus.lane_vld   = vld_q;
   assign bus.lane_data  = data_q;

endmodule

`default_nettype wire
